// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: button synchronisers, IDLE/RUN/LAP/PAUSE sequencing,
// BCD mm:ss.t accumulation of 100 ms ticks and lap-freeze display mux.
module stopwatch_ctrl #(
    parameter int SYNC_STAGES  = 2,
    parameter int MIN_TENS_MAX = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_stop_in,
    input  logic        lap_reset_in,
    input  logic        tick_in,
    output logic        tick_en,
    output logic        tick_clr,
    output logic [19:0] disp_bcd,
    output logic        run_led,
    output logic        lap_led,
    output logic        wrap
);

    typedef enum logic [1:0] {IDLE, RUN, LAP, PAUSE} state_t;

    localparam logic [3:0] MIN_T_LAST = 4'(MIN_TENS_MAX);

    state_t                 r_state;
    state_t                 w_next_state;
    logic [SYNC_STAGES-1:0] r_ss_sync;
    logic [SYNC_STAGES-1:0] r_lr_sync;
    logic                   r_ss_prev;
    logic                   r_lr_prev;
    logic                   r_ss_p;
    logic                   r_lr_p;
    logic [19:0]            r_time;
    logic [19:0]            r_lap;
    logic [19:0]            w_time_inc;
    logic [19:0]            w_time_next;
    logic                   w_rollover;
    logic                   w_tick_acc;
    logic                   w_lap_capture;
    logic                   w_clear_all;
    logic                   r_tick_en;
    logic                   r_tick_clr;
    logic                   r_run_led;
    logic                   r_lap_led;
    logic                   r_wrap;

    // The edge pulse is registered so a press seen at edge N moves the FSM
    // at edge N+SYNC_STAGES+1.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ss_sync <= '0;
            r_lr_sync <= '0;
            r_ss_prev <= 1'b0;
            r_lr_prev <= 1'b0;
            r_ss_p    <= 1'b0;
            r_lr_p    <= 1'b0;
        end else begin
            r_ss_sync <= {r_ss_sync[SYNC_STAGES-2:0], start_stop_in};
            r_lr_sync <= {r_lr_sync[SYNC_STAGES-2:0], lap_reset_in};
            r_ss_prev <= r_ss_sync[SYNC_STAGES-1];
            r_lr_prev <= r_lr_sync[SYNC_STAGES-1];
            r_ss_p    <= r_ss_sync[SYNC_STAGES-1] & ~r_ss_prev;
            r_lr_p    <= r_lr_sync[SYNC_STAGES-1] & ~r_lr_prev;
        end
    end

    // Start/stop has priority: a simultaneous lap/reset pulse is dropped.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_next_state  = r_state;
        w_lap_capture = 1'b0;
        w_clear_all   = 1'b0;
        unique case (r_state)
            IDLE:  if (r_ss_p) w_next_state = RUN;
            RUN: begin
                if (r_ss_p) begin
                    w_next_state = PAUSE;
                end else if (r_lr_p) begin
                    w_next_state  = LAP;
                    w_lap_capture = 1'b1;
                end
            end
            LAP: begin
                if (r_ss_p)      w_next_state = PAUSE;
                else if (r_lr_p) w_next_state = RUN;
            end
            PAUSE: begin
                if (r_ss_p) begin
                    w_next_state = RUN;
                end else if (r_lr_p) begin
                    w_next_state = IDLE;
                    w_clear_all  = 1'b1;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    assign w_tick_acc = tick_in & ((r_state == RUN) | (r_state == LAP));

    // Ripple BCD increment: each digit advances only when all lower digits wrap.
    always_comb begin
        w_time_inc = r_time;
        w_rollover = 1'b0;
        if (r_time[3:0] != 4'd9) begin
            w_time_inc[3:0] = r_time[3:0] + 4'd1;
        end else begin
            w_time_inc[3:0] = 4'd0;
            if (r_time[7:4] != 4'd9) begin
                w_time_inc[7:4] = r_time[7:4] + 4'd1;
            end else begin
                w_time_inc[7:4] = 4'd0;
                if (r_time[11:8] != 4'd5) begin
                    w_time_inc[11:8] = r_time[11:8] + 4'd1;
                end else begin
                    w_time_inc[11:8] = 4'd0;
                    if (r_time[15:12] != 4'd9) begin
                        w_time_inc[15:12] = r_time[15:12] + 4'd1;
                    end else begin
                        w_time_inc[15:12] = 4'd0;
                        if (r_time[19:16] != MIN_T_LAST) begin
                            w_time_inc[19:16] = r_time[19:16] + 4'd1;
                        end else begin
                            w_time_inc[19:16] = 4'd0;
                            w_rollover        = 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign w_time_next = w_tick_acc ? w_time_inc : r_time;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_time     <= '0;
            r_lap      <= '0;
            r_wrap     <= 1'b0;
            r_tick_en  <= 1'b0;
            r_tick_clr <= 1'b1;
            r_run_led  <= 1'b0;
            r_lap_led  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_clear_all) begin
                r_time <= '0;
                r_lap  <= '0;
            end else begin
                r_time <= w_time_next;
                if (w_lap_capture) r_lap <= w_time_next;
            end
            r_wrap     <= w_tick_acc & w_rollover;
            r_tick_en  <= (r_state == RUN) | (r_state == LAP);
            r_tick_clr <= (r_state == IDLE);
            r_run_led  <= (r_state == RUN) | (r_state == LAP);
            r_lap_led  <= (r_state == LAP);
        end
    end

    assign disp_bcd = (r_state == LAP) ? r_lap : r_time;
    assign tick_en  = r_tick_en;
    assign tick_clr = r_tick_clr;
    assign run_led  = r_run_led;
    assign lap_led  = r_lap_led;
    assign wrap     = r_wrap;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl: a default instance and a MIN_TENS_MAX=0
// instance share all inputs so the short-wrap case runs alongside the rest.
module tb_stopwatch_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_stop_in;
    logic        lap_reset_in;
    logic        tick_in;
    logic        tick_en,   tick_clr,   run_led,   lap_led,   wrap;
    logic        tick_en_w, tick_clr_w, run_led_w, lap_led_w, wrap_w;
    logic [19:0] disp_bcd,  disp_bcd_w;
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    stopwatch_ctrl dut (
        .clk(clk), .reset(reset), .start_stop_in(start_stop_in),
        .lap_reset_in(lap_reset_in), .tick_in(tick_in), .tick_en(tick_en),
        .tick_clr(tick_clr), .disp_bcd(disp_bcd), .run_led(run_led),
        .lap_led(lap_led), .wrap(wrap)
    );

    stopwatch_ctrl #(.SYNC_STAGES(2), .MIN_TENS_MAX(0)) dut_w (
        .clk(clk), .reset(reset), .start_stop_in(start_stop_in),
        .lap_reset_in(lap_reset_in), .tick_in(tick_in), .tick_en(tick_en_w),
        .tick_clr(tick_clr_w), .disp_bcd(disp_bcd_w), .run_led(run_led_w),
        .lap_led(lap_led_w), .wrap(wrap_w)
    );

    task automatic check(input string tag, input logic [19:0] obs, input logic [19:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One-cycle press; on return the FSM has moved (edge N+3) and the
    // registered outputs reflect the new state (edge N+4).
    task automatic press(input logic ss, input logic lr);
        start_stop_in = ss;
        lap_reset_in  = lr;
        step(1);
        start_stop_in = 1'b0;
        lap_reset_in  = 1'b0;
        step(4);
    endtask

    task automatic ticks(input int n);
        tick_in = 1'b1;
        step(n);
        tick_in = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, " disp"},    disp_bcd, 20'h00000);
        check({tag, " tick_en"}, 20'(tick_en), 20'd0);
        check({tag, " tick_clr"}, 20'(tick_clr), 20'd1);
        check({tag, " run_led"}, 20'(run_led), 20'd0);
        check({tag, " lap_led"}, 20'(lap_led), 20'd0);
        check({tag, " wrap"},    20'(wrap), 20'd0);
    endtask

    initial begin
        reset         = 1'b1;
        start_stop_in = 1'b0;
        lap_reset_in  = 1'b0;
        tick_in       = 1'b0;

        // 1. Reset state
        step(2);
        reset = 1'b0;
        step(2);
        check_idle("rst");
        check("rst disp_w", disp_bcd_w, 20'h00000);

        // Ticks in IDLE are ignored; lap/reset in IDLE does nothing
        ticks(3);
        press(1'b0, 1'b1);
        check_idle("idle_lr");

        // 2. Start, 25 ticks, stop; further ticks ignored
        press(1'b1, 1'b0);
        check("run tick_en", 20'(tick_en), 20'd1);
        check("run tick_clr", 20'(tick_clr), 20'd0);
        check("run run_led", 20'(run_led), 20'd1);
        ticks(25);
        check("run25 disp", disp_bcd, 20'h00025);
        press(1'b1, 1'b0);
        check("pause disp", disp_bcd, 20'h00025);
        check("pause tick_en", 20'(tick_en), 20'd0);
        check("pause run_led", 20'(run_led), 20'd0);
        ticks(3);
        check("pause ign disp", disp_bcd, 20'h00025);

        // PAUSE + lap/reset -> IDLE with digits cleared
        press(1'b0, 1'b1);
        check_idle("clr");

        // 3. Lap freeze
        press(1'b1, 1'b0);
        ticks(13);
        check("pre_lap disp", disp_bcd, 20'h00013);
        press(1'b0, 1'b1);
        check("lap disp", disp_bcd, 20'h00013);
        check("lap lap_led", 20'(lap_led), 20'd1);
        check("lap run_led", 20'(run_led), 20'd1);
        ticks(7);
        check("lap frozen", disp_bcd, 20'h00013);
        press(1'b0, 1'b1);
        check("unlap disp", disp_bcd, 20'h00020);
        check("unlap lap_led", 20'(lap_led), 20'd0);

        // Lap capture includes a tick arriving on the transition edge
        lap_reset_in = 1'b1;
        step(1);
        lap_reset_in = 1'b0;
        step(2);
        tick_in = 1'b1;
        step(1);
        tick_in = 1'b0;
        check("lap_tick disp", disp_bcd, 20'h00021);
        press(1'b0, 1'b1);
        check("lap_tick live", disp_bcd, 20'h00021);

        // 5. Simultaneous start and lap from IDLE -> RUN only
        press(1'b1, 1'b0);
        press(1'b0, 1'b1);
        check_idle("clr2");
        press(1'b1, 1'b1);
        check("both run_led", 20'(run_led), 20'd1);
        check("both lap_led", 20'(lap_led), 20'd0);
        check("both tick_en", 20'(tick_en), 20'd1);
        ticks(2);
        check("both disp", disp_bcd, 20'h00002);
        press(1'b1, 1'b0);
        press(1'b0, 1'b1);
        check_idle("clr3");

        // 4. Wrap on the MIN_TENS_MAX=0 instance; default instance carries on
        press(1'b1, 1'b0);
        ticks(5999);
        check("pre_wrap disp_w", disp_bcd_w, 20'h09599);
        check("pre_wrap disp", disp_bcd, 20'h09599);
        check("pre_wrap wrap_w", 20'(wrap_w), 20'd0);
        ticks(1);
        check("wrap disp_w", disp_bcd_w, 20'h00000);
        check("wrap wrap_w", 20'(wrap_w), 20'd1);
        check("wrap disp", disp_bcd, 20'h10000);
        check("wrap wrap", 20'(wrap), 20'd0);
        step(1);
        check("wrap_end wrap_w", 20'(wrap_w), 20'd0);
        check("wrap_end disp_w", disp_bcd_w, 20'h00000);

        // Tick on the RUN->PAUSE edge is still counted
        start_stop_in = 1'b1;
        step(1);
        start_stop_in = 1'b0;
        step(2);
        tick_in = 1'b1;
        step(1);
        tick_in = 1'b0;
        step(1);
        check("stop_tick disp", disp_bcd, 20'h10001);
        check("stop_tick disp_w", disp_bcd_w, 20'h00001);
        check("stop_tick tick_en", 20'(tick_en), 20'd0);

        // 6. Async reset mid-RUN at 00:45.6
        press(1'b0, 1'b1);
        press(1'b1, 1'b0);
        ticks(456);
        check("pre_rst disp", disp_bcd, 20'h00456);
        #2;
        reset = 1'b1;
        #1;
        check_idle("async_rst");
        check("async_rst wrap_w", 20'(wrap_w), 20'd0);
        step(2);
        reset = 1'b0;
        step(2);
        check_idle("post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
